// File: rtl/trace_lane_serializer_if.sv
// trace_lane_serializer_if
//   Bundles the retire-side group bus and the sink-side record handshake of
//   trace_lane_serializer.
//   Retire side : in_valid/in_insn/in_addr/in_exc/in_int per lane, plus
//                 in_ecause/in_tval shared by the whole group.
//   Sink side   : out_valid/out_ready handshake and the record fields
//                 out_insn/out_addr/out_exc/out_int/out_ecause/out_tval/
//                 out_lane/out_gap.
//   master = trace source + sink (testbench / core side)
//   slave  = serializer
interface trace_lane_serializer_if #(
    parameter int LANES = 3
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]    in_valid;
    logic [32*LANES-1:0] in_insn;
    logic [32*LANES-1:0] in_addr;
    logic [LANES-1:0]    in_exc;
    logic [LANES-1:0]    in_int;
    logic [4:0]          in_ecause;
    logic [31:0]         in_tval;

    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_insn;
    logic [31:0]         out_addr;
    logic                out_exc;
    logic                out_int;
    logic [4:0]          out_ecause;
    logic [31:0]         out_tval;
    logic [LW-1:0]       out_lane;
    logic                out_gap;

    modport master (
        output in_valid, in_insn, in_addr, in_exc, in_int, in_ecause, in_tval,
        output out_ready,
        input  out_valid, out_insn, out_addr, out_exc, out_int, out_ecause,
        input  out_tval, out_lane, out_gap
    );

    modport slave (
        input  in_valid, in_insn, in_addr, in_exc, in_int, in_ecause, in_tval,
        input  out_ready,
        output out_valid, out_insn, out_addr, out_exc, out_int, out_ecause,
        output out_tval, out_lane, out_gap
    );
endinterface

// File: rtl/trace_lane_serializer.sv
// trace_lane_serializer
//   Packs up to LANES retired-instruction records per cycle (lane order,
//   invalid lanes skipped) into a DEPTH-entry FIFO and drains one record per
//   cycle over a valid/ready handshake. Retirement cannot stall, so a group
//   that does not fit in the space free at the start of the cycle is dropped
//   whole; dropped records are counted and the next stored record carries a
//   gap marker.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard FIFO contents (beats push/pop)
//   clr_drop   : clear drop_cnt / overflow
//   bus        : retire group in, record handshake out (slave modport)
//   drop_cnt   : saturating count of dropped records
//   overflow   : sticky, set on any drop
//   level      : FIFO occupancy
module trace_lane_serializer #(
    parameter int LANES  = 3,
    parameter int DEPTH  = 8,
    parameter int DCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clr_drop,
    trace_lane_serializer_if.slave   bus,
    output logic [DCNT_W-1:0]        drop_cnt,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef struct packed {
        logic [31:0]   insn;
        logic [31:0]   addr;
        logic          exc;
        logic          intr;
        logic [4:0]    ecause;
        logic [31:0]   tval;
        logic [LW-1:0] lane;
        logic          gap;
    } rec_t;

    // Sized to 2**PTR_W so pointer wrap is free; equals DEPTH for DEPTH >= 2.
    rec_t mem [2**PTR_W];

    logic [PTR_W-1:0] wptr, rptr;
    logic             gap_pend;

    // off[i] = number of valid lanes below lane i = slot offset from wptr.
    logic [CNT_W-1:0] off [LANES];
    logic [CNT_W-1:0] n;
    always_comb begin
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            off[i] = n;
            n      = n + CNT_W'(bus.in_valid[i]);
        end
    end

    rec_t             lane_rec [LANES];
    logic [PTR_W-1:0] slot     [LANES];
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_rec[g] = '{
            insn:   bus.in_insn[32*g +: 32],
            addr:   bus.in_addr[32*g +: 32],
            exc:    bus.in_exc[g],
            intr:   bus.in_int[g],
            ecause: bus.in_ecause,
            tval:   bus.in_tval,
            lane:   LW'(g),
            // only the first record of the group inherits the pending gap
            gap:    gap_pend && (off[g] == '0)
        };
        assign slot[g] = wptr + off[g][PTR_W-1:0];
    end

    // Space is judged on the start-of-cycle level: a same-cycle pop does
    // not make room for this cycle's group.
    logic [CNT_W-1:0] free;
    logic             accept, push, drop, pop, out_vld;
    logic [CNT_W-1:0] push_n;
    assign free    = CNT_W'(DEPTH) - level;
    assign accept  = (n <= free);
    assign push    = accept && (n != '0);
    assign drop    = !accept && !flush;
    assign push_n  = accept ? n : '0;
    assign out_vld = (level != '0);
    assign pop     = out_vld && bus.out_ready;

    logic [DCNT_W:0] dsum;
    assign dsum = {1'b0, drop_cnt} + (DCNT_W+1)'(n);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            gap_pend <= 1'b0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
                // anything discarded, stored or incoming, leaves a hole
                if (level != '0 || n != '0) gap_pend <= 1'b1;
            end else begin
                if (pop)  rptr <= rptr + 1'b1;
                if (push) begin
                    wptr     <= wptr + n[PTR_W-1:0];
                    gap_pend <= 1'b0;
                end
                if (drop) gap_pend <= 1'b1;
                level <= level + push_n - CNT_W'(pop);
            end

            if (clr_drop) begin
                drop_cnt <= drop ? DCNT_W'(n) : '0;
                overflow <= drop;
            end else if (drop) begin
                drop_cnt <= dsum[DCNT_W] ? '1 : dsum[DCNT_W-1:0];
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            for (int i = 0; i < LANES; i++)
                if (bus.in_valid[i]) mem[slot[i]] <= lane_rec[i];
        end
    end

    // Head record; fields read as zero whenever the FIFO is empty.
    rec_t head;
    assign head           = mem[rptr];
    assign bus.out_valid  = out_vld;
    assign bus.out_insn   = out_vld ? head.insn   : '0;
    assign bus.out_addr   = out_vld ? head.addr   : '0;
    assign bus.out_exc    = out_vld ? head.exc    : 1'b0;
    assign bus.out_int    = out_vld ? head.intr   : 1'b0;
    assign bus.out_ecause = out_vld ? head.ecause : '0;
    assign bus.out_tval   = out_vld ? head.tval   : '0;
    assign bus.out_lane   = out_vld ? head.lane   : '0;
    assign bus.out_gap    = out_vld ? head.gap    : 1'b0;
endmodule

// File: tb/tb_trace_lane_serializer.sv
module tb_trace_lane_serializer;
    localparam int LANES  = 3;
    localparam int DEPTH  = 8;
    localparam int DCNT_W = 4;
    localparam int DMAX   = (1 << DCNT_W) - 1;

    logic clk = 1'b0;
    logic rst, flush, clr_drop;
    logic [DCNT_W-1:0]      drop_cnt;
    logic                   overflow;
    logic [$clog2(DEPTH):0] level;

    trace_lane_serializer_if #(.LANES(LANES)) bus ();

    trace_lane_serializer #(.LANES(LANES), .DEPTH(DEPTH), .DCNT_W(DCNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clr_drop(clr_drop),
        .bus(bus), .drop_cnt(drop_cnt), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic [1:0]  lane;
        logic        gap;
    } exp_t;

    exp_t sb[$];
    int   mlevel = 0, mdrop = 0;
    bit   movf = 0, mgap = 0;
    int   checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of records, space = DEPTH - count.
    initial forever begin
        int  nv;
        bit  dropped, first, popped;
        @(posedge clk);
        nv = $countones(bus.in_valid);
        dropped = 0;
        if (rst) begin
            sb.delete(); mlevel = 0; mdrop = 0; movf = 0; mgap = 0;
        end else begin
            if (flush) begin
                if (mlevel != 0 || nv > 0) mgap = 1;
                sb.delete();
                mlevel = 0;
            end else begin
                popped = (mlevel > 0) && bus.out_ready;
                if (nv > 0 && nv <= DEPTH - mlevel) begin
                    first = 1;
                    for (int i = 0; i < LANES; i++) begin
                        if (bus.in_valid[i]) begin
                            exp_t e;
                            e.insn   = bus.in_insn[32*i +: 32];
                            e.addr   = bus.in_addr[32*i +: 32];
                            e.exc    = bus.in_exc[i];
                            e.intr   = bus.in_int[i];
                            e.ecause = bus.in_ecause;
                            e.tval   = bus.in_tval;
                            e.lane   = 2'(i);
                            e.gap    = first ? mgap : 1'b0;
                            first    = 0;
                            sb.push_back(e);
                        end
                    end
                    mgap = 0;
                    mlevel += nv;
                end else if (nv > 0) begin
                    dropped = 1;
                    mgap = 1;
                end
                if (popped) mlevel--;
            end
            if (clr_drop) begin
                mdrop = dropped ? nv : 0;
                movf  = dropped;
            end else if (dropped) begin
                mdrop = (mdrop + nv > DMAX) ? DMAX : mdrop + nv;
                movf  = 1;
            end
        end
    end

    // Monitor: status every cycle; record compare on each handshake.
    initial forever begin
        @(negedge clk);
        chk("level", 64'(level), 64'(mlevel));
        chk("out_valid", 64'(bus.out_valid), 64'(mlevel != 0));
        chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        chk("overflow", 64'(overflow), 64'(movf));
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_record", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_addr", 64'(bus.out_addr), 64'(e.addr));
                chk("out_insn", 64'(bus.out_insn), 64'(e.insn));
                chk("out_fields",
                    64'({bus.out_exc, bus.out_int, bus.out_ecause, bus.out_tval, bus.out_lane, bus.out_gap}),
                    64'({e.exc, e.intr, e.ecause, e.tval, e.lane, e.gap}));
            end
        end
    end

    task automatic step(input logic [2:0] v, input logic [31:0] base, input bit rdy,
                        input bit fl = 0, input bit clr = 0, input bit rs = 0);
        bus.in_valid = v;
        for (int i = 0; i < LANES; i++) begin
            bus.in_insn[32*i +: 32] = $urandom;
            bus.in_addr[32*i +: 32] = base + 32'(4 * i);
            bus.in_exc[i] = 1'($urandom);
            bus.in_int[i] = 1'($urandom);
        end
        bus.in_ecause = 5'($urandom);
        bus.in_tval   = $urandom;
        bus.out_ready = rdy;
        flush    = fl;
        clr_drop = clr;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cyc);
        for (int i = 0; i < cyc; i++) step(3'b000, 32'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; clr_drop = 1'b0;
        bus.in_valid = '0; bus.in_insn = '0; bus.in_addr = '0;
        bus.in_exc = '0; bus.in_int = '0; bus.in_ecause = '0; bus.in_tval = '0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        step(3'b000, 0, 0, 0, 0, 1);
        chk("rst_level", 64'(level), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_addr", 64'(bus.out_addr), 0);
        chk("rst_drop", 64'({drop_cnt, overflow}), 0);

        // single-lane stream
        for (int k = 0; k < 5; k++) begin
            step(3'b001, 32'h100 + 32'(4 * k), 1);
            chk("stream_out_valid", 64'(bus.out_valid), 1);
        end
        drain(3);
        chk("stream_drop", 64'(drop_cnt), 0);

        // packing with a lane gap
        step(3'b101, 32'h200, 1);
        chk("pack_level", 64'(level), 2);
        chk("pack_first_lane", 64'({bus.out_addr, bus.out_lane}), 64'({32'h200, 2'd0}));
        drain(3);

        // overflow and gap marker
        step(3'b111, 32'h400, 0);
        step(3'b111, 32'h410, 0);
        chk("ovf_level6", 64'(level), 6);
        step(3'b111, 32'h420, 0);
        chk("ovf_drop3", 64'({drop_cnt, overflow, level}), 64'({4'd3, 1'b1, 4'd6}));
        step(3'b011, 32'h430, 0);
        chk("ovf_level8", 64'(level), 8);
        // full with simultaneous pop still drops
        step(3'b001, 32'h440, 1);
        chk("fullpop", 64'({drop_cnt, level}), 64'({4'd4, 4'd7}));
        drain(9);

        // saturation and clear
        step(3'b000, 0, 0, 0, 1);
        chk("clr0", 64'({drop_cnt, overflow}), 0);
        step(3'b111, 32'h500, 0);
        step(3'b111, 32'h510, 0);
        step(3'b011, 32'h520, 0);
        for (int k = 0; k < 6; k++) step(3'b111, 32'h600, 0);
        chk("sat15", 64'(drop_cnt), 15);
        step(3'b011, 32'h700, 0, 0, 1);
        chk("clr_with_drop", 64'({drop_cnt, overflow}), 64'({4'd2, 1'b1}));
        step(3'b000, 0, 0, 0, 1);
        chk("clr_alone", 64'({drop_cnt, overflow}), 0);
        drain(9);

        // flush
        step(3'b111, 32'h800, 0);
        step(3'b011, 32'h810, 0);
        chk("flush_pre_level", 64'(level), 5);
        step(3'b111, 32'h820, 1, 1);
        chk("flush_level", 64'({level, bus.out_valid}), 0);
        chk("flush_drop", 64'(drop_cnt), 0);
        step(3'b001, 32'h830, 1);
        chk("flush_gap", 64'({bus.out_valid, bus.out_gap, bus.out_addr}), 64'({1'b1, 1'b1, 32'h830}));
        drain(2);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            int rp;
            rp = (k < 750) ? 9 : 6;
            step(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < rp,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 32) == 0,
                 $urandom_range(0, 199) == 0);
        end
        drain(10);

        // reset mid-stream
        step(3'b111, 32'h900, 0);
        step(3'b111, 32'h910, 1);
        step(3'b111, 32'h920, 1);
        step(3'b111, 32'h930, 1, 0, 0, 1);
        chk("midrst", 64'({level, bus.out_valid, drop_cnt, overflow}), 0);
        chk("midrst_data", 64'({bus.out_addr, bus.out_gap}), 0);
        step(3'b001, 32'hA00, 1);
        chk("midrst_nogap", 64'({bus.out_valid, bus.out_gap}), 64'({1'b1, 1'b0}));
        drain(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trace_lane_serializer.md
# trace_lane_serializer

Parametrised retire-trace serializer between the core's per-lane instruction trace outputs and a single-record-per-cycle trace sink. Each cycle it accepts up to LANES retired-instruction records and packs them in lane order into a DEPTH-entry FIFO. It drains the FIFO one record per cycle over a valid/ready handshake. Because retirement cannot be stalled, it drops whole groups on insufficient space, counts the dropped records and tags the next stored record with a gap marker.

## Interface
- LANES, default 3: retire lanes per cycle; 1..4.
- DEPTH, default 8: FIFO entries; power of 2, DEPTH >= LANES.
- DCNT_W, default 16: drop counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  LANES  per-lane retire valid; any bit pattern is legal, including gaps.
- in_insn  in  32*LANES  instruction word, lane i at [32i+31:32i].
- in_addr  in  32*LANES  instruction PC, same packing as in_insn.
- in_exc  in  LANES  lane took an exception.
- in_int  in  LANES  lane took an interrupt.
- in_ecause  in  5  cause, shared by the group.
- in_tval  in  32  trap value, shared by the group.
- flush  in  1  discard all FIFO contents.
- clr_drop  in  1  clear drop counter and overflow flag.
- out_valid  out  1  output record present.
- out_ready  in  1  sink accepts the record.
- out_insn, out_addr  out  32 each  record fields.
- out_exc, out_int  out  1 each  record flags.
- out_ecause  out  5  record cause.
- out_tval  out  32  record trap value.
- out_lane  out  $clog2(LANES) (min 1)  source lane of the record.
- out_gap  out  1  one or more records were dropped immediately before this one.
- drop_cnt  out  DCNT_W  saturating count of dropped records.
- overflow  out  1  sticky; set on any drop.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- The FIFO entry holds {insn, addr, exc, int, ecause, tval, lane, gap}. ecause and tval are copied from the group into every record of that group.
- Group size N = popcount(in_valid). Records are written in ascending lane order into consecutive slots starting at wptr. Lanes with in_valid=0 consume no slot.
- Pop occurs when out_valid && out_ready.
- Accept condition: N <= DEPTH - level, where level is the value at the start of the cycle. A same-cycle pop does not free space for that cycle's push.
- If N > 0 and the group is not accepted, the whole group is dropped; no partial writes occur.
  - drop_cnt increases by N and saturates at 2^DCNT_W - 1.
  - overflow is set.
  - gap_pend is set.
- When a group is accepted and N > 0, the first record written carries gap = gap_pend and gap_pend clears. The remaining records in the group carry gap = 0.
- clr_drop: drop_cnt and overflow are cleared. If a drop occurs in the same cycle, drop_cnt loads N and overflow stays 1. gap_pend is unaffected.
- flush: on the next cycle level=0, wptr=rptr=0 and out_valid=0. A push or pop in the flush cycle is ignored and does not count as a drop. gap_pend is set if level was nonzero or N > 0.
- Priority: rst > flush > push/pop.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level = previous level + N(accepted) - pop, and is never outside 0..DEPTH.
- out_* fields hold the record at rptr and are stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, level=0, drop_cnt=0, overflow=0, gap_pend=0, pointers=0. Other out_* data fields are 0.
- Latency: a record written at edge k is visible with out_valid=1 after edge k, so out_valid goes high the cycle after the input. There is no input-to-output combinational bypass.
- Throughput: 1 record per cycle out, LANES per cycle in.
- out_valid = (level != 0). It is registered state and has no combinational path from in_valid.
- out_ready may toggle freely. The record advances only on a cycle where out_valid && out_ready.
- A full FIFO (level=DEPTH) with a simultaneous pop and N >= 1 drops the group, per the start-of-cycle level rule.
- Reset asserted mid-stream clears all state at the next edge. No record is emitted in the reset cycle.

## Test plan
- Single-lane stream: LANES=3, DEPTH=8, out_ready=1, in_valid=3'b001 for 5 cycles with addr 0x100..0x110 -> out_valid starts 1 cycle later, 5 records in order, out_lane=0, out_gap=0, drop_cnt=0.
- Packing: one cycle with in_valid=3'b101, addr lane0=0x200 and lane2=0x208, out_ready=1 -> two records on consecutive cycles: 0x200 with lane 0, then 0x208 with lane 2; level peaks at 2.
- Overflow: out_ready=0; groups 3'b111 at cycles 0 and 1 bring level to 6; a 3'b111 group at cycle 2 is dropped -> drop_cnt=3, overflow=1, level=6. A following 3'b011 is accepted, its first record has out_gap=1, and level=8.
- Full plus pop: level=8, out_ready=1, in_valid=3'b001 -> group dropped, level=7, drop_cnt increments by 1.
- Saturation and clear: DCNT_W=4, drop 6 groups of 3 records -> drop_cnt=15. Then clr_drop together with a drop of 2 -> drop_cnt=2, overflow=1. Then clr_drop alone -> drop_cnt=0, overflow=0.
- Flush and reset: level=5, assert flush with in_valid=3'b111 -> next cycle level=0, out_valid=0, drop_cnt unchanged, and the next accepted record has out_gap=1. Assert rst mid-stream -> all outputs return to reset values after 1 edge.
